// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared types and constants for the UART command responder.
//   rx_state_t  : serial receiver states
//   asm_state_t : command assembly states (high byte, then low byte)
//   tx_state_t  : response transmitter states
//   RESP_ACK / RESP_NAK : standard response bytes
//   tx_frame()  : builds the 10-bit 8N1 frame, LSB (start bit) first
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    ASM_WAIT_HI = 1'b0,
    ASM_WAIT_LO = 1'b1
  } asm_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_XMIT = 1'b1
  } tx_state_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  // {stop, data[7:0], start}; bit 0 goes on the wire first.
  function automatic logic [9:0] tx_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 serial receiver with a two-flop input synchronizer.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   rx           : raw serial input, idle high, asynchronous to clk
//   rx_byte      : last assembled byte (valid while rx_byte_rdy is high)
//   rx_byte_rdy  : one-cycle pulse, asserted in the stop-bit sample cycle
//                  when the stop bit is high
//
// state    | meaning
// ---------+-------------------------------------------------------
// RX_IDLE  | waiting for a synchronized 1->0 edge
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sample 8 data bits LSB-first, one per bit period
// RX_STOP  | sample stop bit; high -> byte valid, low -> discard
module uart_rx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_rdy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_rdy = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            state_d = RX_IDLE;   // glitch, not a real start bit
          end else begin
            state_d   = RX_DATA;
            cnt_d     = CNT_FULL;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          rx_byte_rdy = rx_sync_q;
          state_d     = RX_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
// Robot-side endpoint of the Bluetooth command link. Pairs received bytes
// into 16-bit commands {first, second} and sends a single response byte.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   RX / TX      : serial in / out, both idle high, 8N1
//   cmd          : last complete command, stable while cmd_rdy is high
//   cmd_rdy      : level, set on command completion
//   clr_cmd_rdy  : pulse, clears cmd_rdy (a same-cycle completion wins)
//   send_resp    : pulse, start transmitting resp (ignored while tx_busy)
//   resp         : response byte, sampled with send_resp
//   resp_sent    : pulse when the stop bit has completed
//   tx_busy      : transmitter mid-frame
// Build option: UART_CMD_TIMEOUT_EN -- abandon a pending high byte after
// TIMEOUT_CYC cycles in WAIT_LO without a second byte.
//
// state       | meaning
// ------------+--------------------------------------------
// ASM_WAIT_HI | waiting for the first (high) command byte
// ASM_WAIT_LO | high byte held, waiting for the low byte
// TX_IDLE     | line idle high, accepts send_resp
// TX_XMIT     | shifting the 10-bit frame out
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);

  logic [7:0] rx_byte;
  logic       rx_byte_rdy;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (RX),
    .rx_byte    (rx_byte),
    .rx_byte_rdy(rx_byte_rdy)
  );

  // ---------------- command assembly ----------------
  asm_state_t  asm_state_q, asm_state_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= TMO_LOAD;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state_q <= ASM_WAIT_HI;
      hi_byte_q   <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      asm_state_q <= asm_state_d;
      hi_byte_q   <= hi_byte_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  always_comb begin
    asm_state_d = asm_state_q;
    hi_byte_d   = hi_byte_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
    // Down-counter reloads whenever a byte arrives or we sit in WAIT_HI.
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (asm_state_q)
      ASM_WAIT_HI: begin
`ifdef UART_CMD_TIMEOUT_EN
        tmo_cnt_d = TMO_LOAD;
`endif
        if (rx_byte_rdy) begin
          hi_byte_d   = rx_byte;
          asm_state_d = ASM_WAIT_LO;
        end
      end
      ASM_WAIT_LO: begin
        if (rx_byte_rdy) begin
          cmd_d       = {hi_byte_q, rx_byte};
          cmd_rdy_d   = 1'b1;
          asm_state_d = ASM_WAIT_HI;
`ifdef UART_CMD_TIMEOUT_EN
          tmo_cnt_d   = TMO_LOAD;
        end else if (tmo_cnt_q == '0) begin
          asm_state_d = ASM_WAIT_HI;   // drop stale high byte
        end else begin
          tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
`endif
        end
      end
      default: asm_state_d = ASM_WAIT_HI;
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  // ---------------- response transmitter ----------------
  tx_state_t        tx_state_q, tx_state_d;
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic             tx_q, tx_d;
  logic             resp_sent_q, resp_sent_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // tx_q is loaded with the bit that will be on the line for the coming
  // bit period, so TX changes exactly on the bit boundary with no decode.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_d        = tx_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (send_resp) begin
          tx_shift_d = tx_frame(resp);
          tx_d       = 1'b0;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = '0;
          tx_state_d = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == 4'd9) begin
            tx_state_d  = TX_IDLE;
            tx_d        = 1'b1;
            resp_sent_d = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX        = tx_q;
  assign resp_sent = resp_sent_q;
  assign tx_busy   = (tx_state_q == TX_XMIT);

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;
  import uart_cmd_pkg::*;

  localparam int BD  = 16;
  localparam int TMO = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;
  logic        tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_drops;
  int rdy_high;

  // Reference model: bytes that arrive intact are paired first/second.
  logic [15:0] exp_cmd;
  logic        exp_rdy;
  logic        have_hi;
  logic [7:0]  exp_hi;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .BAUD_DIV   (BD),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp  (send_resp),
    .resp       (resp),
    .resp_sent  (resp_sent),
    .tx_busy    (tx_busy)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
    have_hi = 1'b0;
    exp_hi  = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!have_hi) begin
      exp_hi  = b;
      have_hi = 1'b1;
    end else begin
      exp_cmd = {exp_hi, b};
      exp_rdy = 1'b1;
      have_hi = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    RX = 1'b1;
    repeat (cycles) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
    if (cycles >= TMO) have_hi = 1'b0;
`endif
  endtask

  task automatic send_bit(input logic v);
    RX = v;
    repeat (BD) begin
      @(negedge clk);
      if (!cmd_rdy) rdy_drops++;
      if (cmd_rdy)  rdy_high++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    if (good) model_byte(b);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (TX !== 1'b1)       begin n_fail++; $display("FAIL reset_tx: got %b expected 1", TX); end
    if (cmd !== 16'h0000)  begin n_fail++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
    if (cmd_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
    if (resp_sent !== 1'b0) begin n_fail++; $display("FAIL reset_resp_sent: got %b expected 0", resp_sent); end
    if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    send_byte(8'h23, 1'b1);
    send_byte(8'hFF, 1'b1);
    n_checks += 3;
    if (cmd !== 16'h23FF)    begin n_fail++; $display("FAIL basic_cmd: got %h expected 23ff", cmd); end
    if (cmd !== exp_cmd)     begin n_fail++; $display("FAIL basic_model: got %h expected %h", cmd, exp_cmd); end
    if (cmd_rdy !== 1'b1)    begin n_fail++; $display("FAIL basic_rdy: got %b expected 1", cmd_rdy); end
    pulse_clr();
    n_checks += 2;
    if (cmd_rdy !== 1'b0)    begin n_fail++; $display("FAIL clr_rdy: got %b expected 0", cmd_rdy); end
    if (cmd !== 16'h23FF)    begin n_fail++; $display("FAIL clr_cmd_kept: got %h expected 23ff", cmd); end
  endtask

  task automatic test_overwrite();
    send_byte(8'h40, 1'b1);
    send_byte(8'h02, 1'b1);
    n_checks += 2;
    if (cmd !== exp_cmd)  begin n_fail++; $display("FAIL ovw_first_cmd: got %h expected %h", cmd, exp_cmd); end
    if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL ovw_first_rdy: got %b expected 1", cmd_rdy); end
    rdy_drops = 0;
    send_byte(8'h60, 1'b1);
    n_checks += 1;
    if (cmd !== 16'h4002) begin n_fail++; $display("FAIL ovw_stable: got %h expected 4002", cmd); end
    send_byte(8'h00, 1'b1);
    n_checks += 3;
    if (cmd !== 16'h6000) begin n_fail++; $display("FAIL ovw_cmd: got %h expected 6000", cmd); end
    if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL ovw_rdy: got %b expected 1", cmd_rdy); end
    if (rdy_drops != 0)   begin n_fail++; $display("FAIL ovw_rdy_held: %0d low cycles, expected 0", rdy_drops); end
  endtask

  task automatic test_calibrate();
    pulse_clr();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    n_checks += 2;
    if (cmd !== 16'h0000) begin n_fail++; $display("FAIL calib_cmd: got %h expected 0000", cmd); end
    if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL calib_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task automatic test_tx(input logic [7:0] r, input logic do_ignore);
    logic [9:0] frame;
    frame = {1'b1, r, 1'b0};
    @(negedge clk);
    send_resp = 1'b1; resp = r;
    @(negedge clk);
    send_resp = 1'b0; resp = ~r;
    for (int n = 0; n < 166; n++) begin
      if (n < 160) begin
        if ((n % 16 == 1) || (n % 16 == 8)) begin
          n_checks++;
          if (TX !== frame[n/16]) begin
            n_fail++;
            $display("FAIL tx_bit%0d (resp %h, cyc %0d): got %b expected %b", n/16, r, n, TX, frame[n/16]);
          end
        end
        if (n == 0 || n == 159) begin
          n_checks++;
          if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_hi cyc %0d: got %b expected 1", n, tx_busy); end
        end
      end else if (n == 160) begin
        n_checks += 2;
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL tx_busy_end: got %b expected 0", tx_busy); end
        if (TX !== 1'b1)      begin n_fail++; $display("FAIL tx_idle_after: got %b expected 1", TX); end
      end
      n_checks++;
      if (resp_sent !== (n == 160)) begin
        n_fail++;
        $display("FAIL resp_sent cyc %0d: got %b expected %b", n, resp_sent, (n == 160));
      end
      if (do_ignore && n == 49) begin send_resp = 1'b1; resp = 8'h00; end
      if (n == 50) send_resp = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_glitch_framing();
    int g;
    logic [7:0] a, b;
    pulse_clr();
    g = $urandom_range(1, 5);
    RX = 1'b0;
    repeat (g) @(negedge clk);
    idle(40);
    send_byte(8'h5A, 1'b0);
    a = 8'($urandom); b = 8'($urandom);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    n_checks += 2;
    if (cmd !== {a, b})   begin n_fail++; $display("FAIL glitch_frame_cmd: got %h expected %h", cmd, {a, b}); end
    if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL glitch_frame_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) pulse_clr();
      if ($urandom_range(0, 3) == 0) begin
        RX = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        idle(30);
      end
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0);
      a = 8'($urandom);
      send_byte(a, 1'b1);
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0);
      b = 8'($urandom);
      send_byte(b, 1'b1);
      n_checks += 2;
      if (cmd !== exp_cmd)     begin n_fail++; $display("FAIL rand%0d_cmd: got %h expected %h", it, cmd, exp_cmd); end
      if (cmd_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand%0d_rdy: got %b expected %b", it, cmd_rdy, exp_rdy); end
    end
  endtask

  // clr held high across a completion: set wins for one cycle, then clears.
  task automatic test_clr_collision();
    pulse_clr();
    clr_cmd_rdy = 1'b1;
    send_byte(8'hC3, 1'b1);
    rdy_high = 0;
    send_byte(8'h3C, 1'b1);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (rdy_high != 1)       begin n_fail++; $display("FAIL collision_set_wins: rdy high %0d cycles, expected 1", rdy_high); end
    if (cmd !== 16'hC33C)    begin n_fail++; $display("FAIL collision_cmd: got %h expected c33c", cmd); end
    if (cmd_rdy !== exp_rdy) begin n_fail++; $display("FAIL collision_rdy: got %b expected %b", cmd_rdy, exp_rdy); end
  endtask

  task automatic test_concurrent();
    logic [7:0] a, b, r;
    a = 8'($urandom); b = 8'($urandom); r = 8'($urandom);
    fork
      begin
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
      end
      begin
        repeat (20) @(negedge clk);
        test_tx(r, 1'b0);
      end
    join
    n_checks += 2;
    if (cmd !== {a, b})   begin n_fail++; $display("FAIL concurrent_cmd: got %h expected %h", cmd, {a, b}); end
    if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL concurrent_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task automatic test_timeout_cfg();
    logic [15:0] want;
    pulse_clr();
    send_byte(8'h12, 1'b1);
    idle(600);
    send_byte(8'h34, 1'b1);
`ifdef UART_CMD_TIMEOUT_EN
    send_byte(8'h56, 1'b1);
    want = 16'h3456;
`else
    want = 16'h1234;
`endif
    n_checks += 3;
    if (cmd !== want)        begin n_fail++; $display("FAIL timeout_cmd: got %h expected %h", cmd, want); end
    if (cmd !== exp_cmd)     begin n_fail++; $display("FAIL timeout_model: got %h expected %h", cmd, exp_cmd); end
    if (cmd_rdy !== 1'b1)    begin n_fail++; $display("FAIL timeout_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] a, b;
    @(negedge clk);
    send_resp = 1'b1; resp = 8'h00;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (TX !== 1'b1)      begin n_fail++; $display("FAIL midrst_tx: got %b expected 1", TX); end
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", tx_busy); end
    if (cmd !== 16'h0000) begin n_fail++; $display("FAIL midrst_cmd: got %h expected 0000", cmd); end
    if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy: got %b expected 0", cmd_rdy); end
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    a = 8'($urandom); b = 8'($urandom);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    n_checks += 2;
    if (cmd !== {a, b})   begin n_fail++; $display("FAIL midrst_pair: got %h expected %h", cmd, {a, b}); end
    if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_pair_rdy: got %b expected 1", cmd_rdy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_calibrate();
    test_tx(RESP_ACK, 1'b1);
    test_tx(8'($urandom), 1'b0);
    test_tx(RESP_NAK, 1'b0);
    test_glitch_framing();
    test_random();
    test_clr_collision();
    test_concurrent();
    test_timeout_cfg();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

- Robot-side endpoint of the Bluetooth command link.
- Receives 8N1 UART bytes on RX and assembles each high/low byte pair into a 16-bit command for the command processor.
- Transmits a single response byte (normally 0xA5, the positive acknowledge) back on TX on request.
- Sits inside MazeRunner between the RX/TX pins and the command processor; it is the counterpart of the remote command sender.

## Interface
Parameters:
- BAUD_DIV, 2604: clock cycles per bit (50 MHz / 19200 baud); minimum 8.
- TIMEOUT_CYC, 1000000: maximum idle cycles between high and low byte (used only with the timeout option).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  serial input from the Bluetooth module; idle high; asynchronous to clk.
- TX  out  1  serial output to the Bluetooth module; idle high.
- cmd  out  16  last complete command, {first byte, second byte}.
- cmd_rdy  out  1  level; a complete command is held in cmd.
- clr_cmd_rdy  in  1  one-cycle pulse from the consumer; clears cmd_rdy.
- send_resp  in  1  one-cycle pulse; start transmitting resp.
- resp  in  8  response byte; sampled on the send_resp cycle.
- resp_sent  out  1  one-cycle pulse when the response stop bit completes.
- tx_busy  out  1  transmitter is mid-frame.

## Operation
RX synchronizer and receiver:
- RX passes through a 2-flop synchronizer (both flops reset to 1).
- Start is detected on a synchronized 1→0 transition while the receiver is idle.
- Receiver states: IDLE, START, DATA, STOP.
- START: wait BAUD_DIV/2 cycles, then re-sample the line. If it is high, the start was false; return to IDLE with no byte.
- DATA: sample 8 bits LSB-first, each BAUD_DIV cycles after the previous sample.
- STOP: sample once more after BAUD_DIV cycles. If high, raise an internal rx_byte_rdy pulse for one cycle. If low (framing error), discard the byte. Either way, return to IDLE.

Assembly FSM:
- States: WAIT_HI, WAIT_LO.
- WAIT_HI + byte: store the byte in hi_byte (internal); go to WAIT_LO.
- WAIT_LO + byte: cmd <= {hi_byte, byte}; set cmd_rdy; go to WAIT_HI.
- cmd changes only on completion, so it is stable while cmd_rdy is high.
- Completion while cmd_rdy is already 1: cmd is overwritten and cmd_rdy stays 1.
- clr_cmd_rdy and completion in the same cycle: the set wins.
- Framing errors do not change FSM state.

Transmitter:
- States: IDLE, XMIT.
- send_resp in IDLE: latch resp into a 10-bit shift register {1, resp, 0}.
- Shift LSB first, one bit per BAUD_DIV cycles.
- After the 10th bit period: pulse resp_sent and return to IDLE.
- send_resp while tx_busy is ignored; the frame in flight is unaffected.
- TX is driven from a flop (glitch-free).

Reset:
- Reset mid-frame (either direction) aborts immediately.
- Reset values: TX=1, cmd=0x0000, cmd_rdy=0, resp_sent=0, tx_busy=0; both FSMs in their idle/WAIT_HI state.

## Timing
- TX falls on the first clk edge after the send_resp cycle.
- tx_busy rises in that same cycle and stays high for exactly 10·BAUD_DIV cycles.
- resp_sent coincides with the cycle in which tx_busy falls.
- Each RX bit is sampled BAUD_DIV/2 (±1) cycles after its nominal edge.
- Start-detect latency is 2 cycles, from the synchronizer.
- cmd and cmd_rdy update on the cycle after the low byte's stop-bit sample: about 9.5·BAUD_DIV + 3 cycles after the low byte's start edge.
- RX and TX operate fully concurrently.

## Configuration
- UART_CMD_TIMEOUT_EN defined: in WAIT_LO, a counter runs from 0. At TIMEOUT_CYC with no second byte, hi_byte is discarded and the FSM returns to WAIT_HI; cmd and cmd_rdy are untouched. The counter clears whenever a byte arrives.
- Undefined: WAIT_LO waits indefinitely, and no counter is synthesized.

## Structure
- Package uart_cmd_pkg contains:
  - enums rx_state_t, asm_state_t, tx_state_t;
  - localparam RESP_ACK = 8'hA5;
  - localparam RESP_NAK = 8'hEE.
- Sub-module uart_rx (synchronizer, receiver FSM, rx_byte, rx_byte_rdy) is natural.
- The transmitter and assembly FSM live in the top module.

## Test plan
- BAUD_DIV=16. Send bytes 0x23, 0xFF → cmd=0x23FF, cmd_rdy=1. Pulse clr_cmd_rdy → cmd_rdy=0 next cycle, cmd still 0x23FF.
- Send 0x40, 0x02, then 0x60, 0x00 without clearing → cmd=0x6000, cmd_rdy held at 1 throughout.
- Send 0x00, 0x00 (calibrate) → cmd=0x0000, cmd_rdy=1.
- Pulse send_resp with resp=0xA5 → TX shows 0,1,0,1,0,0,1,0,1,1 at 16-cycle bit intervals; resp_sent pulses at cycle 160. A second send_resp at cycle 50 is ignored.
- 4-cycle RX low glitch → no byte received. A byte with stop bit 0 → discarded; the following two valid bytes form cmd.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYC=500: send 0x12, idle 600 cycles, then send 0x34, 0x56 → cmd=0x3456.
